// File: rtl/seg_scan_decoder.sv
// Recovers BCD digit values from a multiplexed, active-low 7-segment display bus.
// Each anode/segment pair must hold steady before it is decoded into a per-digit capture register.
module seg_scan_decoder #(
   parameter int N_DIGITS      = 4,
   parameter int STABLE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_DIGITS-1:0]   an_in,
   input  logic [7:0]            seg_in,
   input  logic                  clear,
   output logic [4*N_DIGITS-1:0] digits,
   output logic [N_DIGITS-1:0]   valid,
   output logic [N_DIGITS-1:0]   err,
   output logic                  upd_stb,
   output logic [2:0]            upd_idx,
   output logic [3:0]            upd_val,
   output logic                  frame_done
);

   localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } state_t;

   function automatic logic [3:0] seg_decode(input logic [6:0] pat);
      logic [3:0] v;
      case (pat)
         7'h40:   v = 4'd0;
         7'h79:   v = 4'd1;
         7'h24:   v = 4'd2;
         7'h30:   v = 4'd3;
         7'h19:   v = 4'd4;
         7'h12:   v = 4'd5;
         7'h02:   v = 4'd6;
         7'h78:   v = 4'd7;
         7'h00:   v = 4'd8;
         7'h18:   v = 4'd9;
         7'h7F:   v = 4'hE;
         default: v = 4'hF;
      endcase
      return v;
   endfunction

   logic [N_DIGITS-1:0]   an_meta_q, s_an_q, prev_an_q;
   logic [6:0]            seg_meta_q, s_seg_q, prev_seg_q;
   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [3:0]            n_low;
   logic [2:0]            an_idx;
   logic                  an_ok;
   logic                  pair_same;
   logic                  capture;
   logic [3:0]            dec_val;
   logic [4*N_DIGITS-1:0] digits_q, digits_d;
   logic [N_DIGITS-1:0]   valid_q, valid_d;
   logic [N_DIGITS-1:0]   err_q, err_d;
   logic                  fd_q, fd_d;
   logic                  stb_q, stb_d;
   logic [2:0]            idx_q, idx_d;
   logic [3:0]            val_q, val_d;
   logic                  unused_dp;

   assign unused_dp = seg_in[7];

   // Two-flop synchronisers plus the previous-pair register; idle display is all ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_meta_q  <= '1;
         s_an_q     <= '1;
         prev_an_q  <= '1;
         seg_meta_q <= '1;
         s_seg_q    <= '1;
         prev_seg_q <= '1;
      end else begin
         an_meta_q  <= an_in;
         s_an_q     <= an_meta_q;
         prev_an_q  <= s_an_q;
         seg_meta_q <= seg_in[6:0];
         s_seg_q    <= seg_meta_q;
         prev_seg_q <= s_seg_q;
      end
   end

   always_comb begin
      n_low  = '0;
      an_idx = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (!s_an_q[i]) begin
            n_low  = n_low + 4'd1;
            an_idx = 3'(i);
         end
      end
   end

   assign an_ok     = (n_low == 4'd1);
   assign pair_same = (s_an_q == prev_an_q) && (s_seg_q == prev_seg_q);
   assign dec_val   = seg_decode(s_seg_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_WAIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_WAIT: begin
            cnt_d = '0;
            if (an_ok) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (!an_ok) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end else if (!pair_same) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HELD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HELD: begin
            cnt_d = '0;
            if (!an_ok) state_d = ST_WAIT;
            else if (!pair_same) state_d = ST_SETTLE;
         end
         default: begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      capture = (state_q == ST_SETTLE) && an_ok && pair_same && (cnt_q == CNT_LAST);
   end

   // clear beats a coincident capture for the capture registers, but the strobe still fires.
   always_comb begin
      digits_d = digits_q;
      valid_d  = valid_q;
      err_d    = err_q;
      fd_d     = &valid_q;
      stb_d    = capture;
      idx_d    = idx_q;
      val_d    = val_q;
      if (capture) begin
         idx_d = an_idx;
         val_d = dec_val;
      end
      if (clear) begin
         digits_d = '1;
         valid_d  = '0;
         err_d    = '0;
         fd_d     = 1'b0;
      end else if (capture) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            if (an_idx == 3'(i)) begin
               digits_d[4*i +: 4] = dec_val;
               valid_d[i]         = 1'b1;
               err_d[i]           = (dec_val == 4'hF);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digits_q <= '1;
         valid_q  <= '0;
         err_q    <= '0;
         fd_q     <= 1'b0;
         stb_q    <= 1'b0;
         idx_q    <= '0;
         val_q    <= '0;
      end else begin
         digits_q <= digits_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         fd_q     <= fd_d;
         stb_q    <= stb_d;
         idx_q    <= idx_d;
         val_q    <= val_d;
      end
   end

   assign digits     = digits_q;
   assign valid      = valid_q;
   assign err        = err_q;
   assign frame_done = fd_q;
   assign upd_stb    = stb_q;
   assign upd_idx    = idx_q;
   assign upd_val    = val_q;

endmodule
